sigdel_ctrl: RTL and testbench
==============================

# sigdel_ctrl

Front-end sequencer for the first-order sigma-delta modulator. Accepts PCM samples over a valid/ready handshake and holds each sample on the modulator input for OSR modulator clocks. Manages start-up, clean shutdown with an idle-tone mute period, underrun handling, and overload (long bit-run) detection. Sits between the sample source (decimation/interpolation or a host FIFO) and the modulator instance; the bitstream returns through this block to downstream logic.

## Interface
- INPUT_BITWIDTH, 24, signed sample width; matches the modulator input.
- OSR, 64, modulator clocks per input sample; must be ≥ 2.
- OVL_LIMIT, 32, run length of identical modulator bits that flags overload; must be ≥ 2.
- mod_clock  in  1  modulator clock; the only clock.
- mod_reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  run request; sampled every cycle.
- in_data  in  INPUT_BITWIDTH  signed PCM sample.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle (combinational).
- mod_input  out  INPUT_BITWIDTH  registered drive to the modulator input_sig.
- mod_bit  in  1  modulator output_sig.
- bit_out  out  1  registered copy of mod_bit.
- bit_valid  out  1  bit_out belongs to a live frame.
- frame_start  out  1  one-cycle pulse on the first clock of each frame.
- overload  out  1  live overload flag.
- overload_sticky  out  1  latched overload; cleared by clear_flags.
- underrun_sticky  out  1  latched underrun; cleared by clear_flags.
- clear_flags  in  1  synchronous clear of both sticky flags.

## Operation
- States:
  - IDLE: mod_input = 0; in_ready = 0. Goes to FILL when enable = 1.
  - FILL: in_ready = 1. A handshake latches in_data, sets cnt = 0, pulses frame_start, and goes to RUN. If enable = 0, goes to IDLE.
  - RUN: mod_input holds the latched sample. cnt increments from 0 to OSR-1. At cnt = OSR-1:
    - If enable = 1 and in_valid = 1: accept the new sample, wrap cnt to 0, pulse frame_start.
    - If enable = 1 and in_valid = 0: repeat the last sample, set underrun_sticky, wrap cnt, pulse frame_start.
    - If enable = 0: set mod_input = 0, cnt = 0, and go to MUTE.
    - A drop of enable mid-frame takes effect only at the frame boundary.
  - MUTE: mod_input = 0; bit_valid = 1; enable is ignored. At cnt = OSR-1, goes to IDLE.
- in_ready = (state == FILL) || (state == RUN && cnt == OSR-1 && enable).
- Handshake occurs when in_valid && in_ready. in_data is not stored otherwise. in_valid may be held without penalty.
- Bitstream: bit_out <= mod_bit every cycle. bit_valid <= (state is RUN or MUTE).
- Overload:
  - run_cnt counts consecutive equal mod_bit values while in RUN. It saturates at OVL_LIMIT.
  - run_cnt resets to 1 when mod_bit changes, and to 0 outside RUN.
  - overload = (run_cnt == OVL_LIMIT), registered.
  - overload_sticky sets whenever overload = 1.
- clear_flags clears the sticky flags. If a clear coincides with a set event in the same cycle, the set wins.
- Arithmetic: cnt width clog2(OSR); run_cnt width clog2(OVL_LIMIT+1). No arithmetic is performed on the sample path; samples pass through bit-exact.

## Timing
- Reset (async assert, sync release): state = IDLE, cnt = 0, mod_input = 0, bit_out = 0, bit_valid = 0, frame_start = 0, overload = 0, both sticky flags = 0, run_cnt = 0.
- Latency:
  - A sample accepted at edge N appears on mod_input after edge N.
  - frame_start is high in the cycle after the handshake edge.
  - mod_bit to bit_out: 1 cycle.
- Frame period is exactly OSR cycles, and frames are back-to-back with no gap.
- Throughput: at most 1 sample per OSR cycles.
- Reset asserted mid-frame: all outputs return to reset values immediately; no MUTE period runs.

## Structure
- Shared package sigdel_pkg holds:
  - the state enumeration (IDLE, FILL, RUN, MUTE);
  - the default INPUT_BITWIDTH;
  - FULL_POS/FULL_NEG constants, also used by the modulator.
- Sub-module sigdel_run_detect holds the run_cnt logic, overload, and overload_sticky.
- The FSM, frame counter, and sample register stay in the top level.

## Test plan
- Start-up, OSR=8: enable=1, present 24'h100000 with in_valid=1 → in_ready high in FILL. mod_input = 24'h100000 one cycle later. frame_start pulses every 8 cycles.
- Back-to-back, OSR=8: samples 24'h000010, 24'h7FFFFF, 24'h800000 held valid → each accepted at cnt=7. mod_input changes exactly every 8 cycles. underrun_sticky stays 0.
- Underrun: withhold in_valid at the second boundary → mod_input repeats the prior value, underrun_sticky = 1. clear_flags=1 then clears it.
- Shutdown: drop enable at cnt=3 → RUN continues to cnt=7, then MUTE for 8 cycles with mod_input = 0 and bit_valid = 1, then IDLE with bit_valid = 0.
- Overload, OVL_LIMIT=4: force mod_bit=1 for 6 cycles in RUN → overload rises after the 4th equal bit (plus 1 register cycle) and drops after mod_bit toggles. overload_sticky stays 1.
- Async reset in RUN mid-frame → all outputs 0 during reset. After release, state is IDLE and in_ready = 0 until enable is asserted.

Source files
------------

// File: rtl/sigdel_pkg.sv
// Shared definitions for the sigma-delta front end and the modulator.
package sigdel_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2,
      MUTE = 2'd3
   } sigdel_state_t;

   localparam int SIGDEL_INPUT_BITWIDTH = 24;

   // Full-scale input codes, shared with the modulator's feedback DAC.
   localparam logic signed [SIGDEL_INPUT_BITWIDTH-1:0] FULL_POS =
      {1'b0, {(SIGDEL_INPUT_BITWIDTH-1){1'b1}}};
   localparam logic signed [SIGDEL_INPUT_BITWIDTH-1:0] FULL_NEG =
      {1'b1, {(SIGDEL_INPUT_BITWIDTH-1){1'b0}}};

   function automatic logic is_live(sigdel_state_t s);
      return (s == RUN) || (s == MUTE);
   endfunction

endpackage

// File: rtl/sigdel_run_detect.sv
// Overload detector: counts consecutive equal modulator bits while running.
module sigdel_run_detect #(
   parameter int OVL_LIMIT = 32
) (
   input  logic mod_clock,
   input  logic mod_reset_n,
   input  logic in_run,
   input  logic mod_bit,
   input  logic clear_flags,
   output logic overload,
   output logic overload_sticky
);

   localparam int RW = $clog2(OVL_LIMIT + 1);
   localparam logic [RW-1:0] LIMIT = RW'(OVL_LIMIT);

   logic [RW-1:0] run_cnt;
   logic          last_bit;

   always_ff @(posedge mod_clock or negedge mod_reset_n) begin
      if (!mod_reset_n) begin
         run_cnt  <= '0;
         last_bit <= 1'b0;
      end else begin
         last_bit <= mod_bit;
         if (!in_run)
            run_cnt <= '0;
         // First bit of a run (or first bit after entering RUN) restarts at 1.
         else if (run_cnt == '0 || mod_bit != last_bit)
            run_cnt <= RW'(1);
         else if (run_cnt != LIMIT)
            run_cnt <= run_cnt + 1'b1;
      end
   end

   always_ff @(posedge mod_clock or negedge mod_reset_n) begin
      if (!mod_reset_n) begin
         overload        <= 1'b0;
         overload_sticky <= 1'b0;
      end else begin
         overload <= (run_cnt == LIMIT);
         if (overload)
            overload_sticky <= 1'b1;
         else if (clear_flags)
            overload_sticky <= 1'b0;
      end
   end

endmodule

// File: rtl/sigdel_ctrl.sv
// Sample sequencer for the sigma-delta modulator: holds each PCM sample for OSR
// clocks, handles start-up, mute-on-shutdown, underrun and overload reporting.
module sigdel_ctrl
   import sigdel_pkg::*;
#(
   parameter int INPUT_BITWIDTH = SIGDEL_INPUT_BITWIDTH,
   parameter int OSR            = 64,
   parameter int OVL_LIMIT      = 32
) (
   input  logic                      mod_clock,
   input  logic                      mod_reset_n,
   input  logic                      enable,
   input  logic [INPUT_BITWIDTH-1:0] in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [INPUT_BITWIDTH-1:0] mod_input,
   input  logic                      mod_bit,
   output logic                      bit_out,
   output logic                      bit_valid,
   output logic                      frame_start,
   output logic                      overload,
   output logic                      overload_sticky,
   output logic                      underrun_sticky,
   input  logic                      clear_flags
);

   localparam int CW = (OSR > 1) ? $clog2(OSR) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(OSR - 1);

   sigdel_state_t state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          cnt_last, hs;
   logic          load, fs_nxt, urun_set, mute_zero;

   assign cnt_last = (cnt == CNT_LAST);
   assign in_ready = (state == FILL) || (state == RUN && cnt_last && enable);
   assign hs       = in_valid && in_ready;

   always_ff @(posedge mod_clock or negedge mod_reset_n) begin
      if (!mod_reset_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Enable is only acted on at frame boundaries so a frame is never truncated.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      load      = 1'b0;
      fs_nxt    = 1'b0;
      urun_set  = 1'b0;
      mute_zero = 1'b0;
      case (state)
         IDLE: if (enable) state_nxt = FILL;
         FILL: begin
            if (hs) begin
               load      = 1'b1;
               cnt_nxt   = '0;
               fs_nxt    = 1'b1;
               state_nxt = RUN;
            end else if (!enable) begin
               state_nxt = IDLE;
            end
         end
         RUN: begin
            if (!cnt_last) begin
               cnt_nxt = cnt + 1'b1;
            end else begin
               cnt_nxt = '0;
               if (enable) begin
                  fs_nxt = 1'b1;
                  if (in_valid) load     = 1'b1;
                  else          urun_set = 1'b1;
               end else begin
                  mute_zero = 1'b1;
                  state_nxt = MUTE;
               end
            end
         end
         MUTE: begin
            if (!cnt_last) begin
               cnt_nxt = cnt + 1'b1;
            end else begin
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // mod_input doubles as the sample register; an underrun simply leaves it alone.
   always_ff @(posedge mod_clock or negedge mod_reset_n) begin
      if (!mod_reset_n) begin
         mod_input       <= '0;
         frame_start     <= 1'b0;
         underrun_sticky <= 1'b0;
         bit_out         <= 1'b0;
         bit_valid       <= 1'b0;
      end else begin
         if (load)
            mod_input <= in_data;
         else if (mute_zero)
            mod_input <= '0;
         frame_start <= fs_nxt;
         if (urun_set)
            underrun_sticky <= 1'b1;
         else if (clear_flags)
            underrun_sticky <= 1'b0;
         bit_out   <= mod_bit;
         bit_valid <= is_live(state);
      end
   end

   sigdel_run_detect #(
      .OVL_LIMIT (OVL_LIMIT)
   ) u_run_detect (
      .mod_clock       (mod_clock),
      .mod_reset_n     (mod_reset_n),
      .in_run          (state == RUN),
      .mod_bit         (mod_bit),
      .clear_flags     (clear_flags),
      .overload        (overload),
      .overload_sticky (overload_sticky)
   );

endmodule

// File: tb/tb_sigdel_ctrl.sv
// Directed bench for sigdel_ctrl with OSR=8, OVL_LIMIT=4.
module tb_sigdel_ctrl;

   localparam int W   = 24;
   localparam int OSR = 8;
   localparam int OVL = 4;

   logic         mod_clock = 1'b0;
   logic         mod_reset_n = 1'b0;
   logic         enable = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] mod_input;
   logic         mod_bit = 1'b0;
   logic         bit_out, bit_valid, frame_start;
   logic         overload, overload_sticky, underrun_sticky;
   logic         clear_flags = 1'b0;

   int checks = 0;
   int failures = 0;

   always #5 mod_clock = ~mod_clock;

   sigdel_ctrl #(.INPUT_BITWIDTH(W), .OSR(OSR), .OVL_LIMIT(OVL)) dut (
      .mod_clock       (mod_clock),
      .mod_reset_n     (mod_reset_n),
      .enable          (enable),
      .in_data         (in_data),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .mod_input       (mod_input),
      .mod_bit         (mod_bit),
      .bit_out         (bit_out),
      .bit_valid       (bit_valid),
      .frame_start     (frame_start),
      .overload        (overload),
      .overload_sticky (overload_sticky),
      .underrun_sticky (underrun_sticky),
      .clear_flags     (clear_flags)
   );

   task automatic step(input int n);
      repeat (n) @(negedge mod_clock);
   endtask

   task automatic do_reset();
      mod_reset_n = 1'b0;
      enable = 1'b0; in_valid = 1'b0; in_data = '0; mod_bit = 1'b0; clear_flags = 1'b0;
      step(2);
      mod_reset_n = 1'b1;
   endtask

   // Leaves the DUT in RUN with cnt=0, at the negedge after the handshake.
   task automatic start(input logic [W-1:0] d);
      enable = 1'b1; in_valid = 1'b1; in_data = d;
      step(2);
      checks++; if (mod_input !== d) begin failures++; $display("FAIL start_mod_input got=%h exp=%h", mod_input, d); end
      checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL start_frame_start got=%b exp=1", frame_start); end
   endtask

   task automatic test_reset();
      mod_reset_n = 1'b0; mod_bit = 1'b1; enable = 1'b1; in_valid = 1'b1;
      step(2);
      checks++; if (mod_input !== '0) begin failures++; $display("FAIL rst_mod_input got=%h exp=0", mod_input); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
      checks++; if ({bit_out, bit_valid, frame_start} !== 3'b000) begin failures++; $display("FAIL rst_bits got=%b exp=000", {bit_out, bit_valid, frame_start}); end
      checks++; if ({overload, overload_sticky, underrun_sticky} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {overload, overload_sticky, underrun_sticky}); end
      do_reset();
   endtask

   task automatic test_startup();
      do_reset();
      enable = 1'b1; in_valid = 1'b1; in_data = 24'h100000;
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL su_idle_ready got=%b exp=0", in_ready); end
      step(1);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL su_fill_ready got=%b exp=1", in_ready); end
      checks++; if (mod_input !== '0) begin failures++; $display("FAIL su_fill_mod_input got=%h exp=0", mod_input); end
      step(1);
      checks++; if (mod_input !== 24'h100000) begin failures++; $display("FAIL su_mod_input got=%h exp=100000", mod_input); end
      checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL su_fs0 got=%b exp=1", frame_start); end
      checks++; if (bit_valid !== 1'b0) begin failures++; $display("FAIL su_bv0 got=%b exp=0", bit_valid); end
      for (int k = 1; k <= 16; k++) begin
         step(1);
         checks++; if (frame_start !== (k % 8 == 0)) begin failures++; $display("FAIL su_fs k=%0d got=%b exp=%b", k, frame_start, (k % 8 == 0)); end
         checks++; if (in_ready !== (k % 8 == 7)) begin failures++; $display("FAIL su_ready k=%0d got=%b exp=%b", k, in_ready, (k % 8 == 7)); end
         checks++; if (bit_valid !== 1'b1) begin failures++; $display("FAIL su_bv k=%0d got=%b exp=1", k, bit_valid); end
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] seq [3];
      seq[0] = 24'h000010; seq[1] = 24'h7FFFFF; seq[2] = 24'h800000;
      do_reset();
      start(seq[0]);
      for (int s = 1; s < 3; s++) begin
         in_data = seq[s];
         step(7);
         checks++; if (mod_input !== seq[s-1]) begin failures++; $display("FAIL b2b_hold s=%0d got=%h exp=%h", s, mod_input, seq[s-1]); end
         checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready s=%0d got=%b exp=1", s, in_ready); end
         step(1);
         checks++; if (mod_input !== seq[s]) begin failures++; $display("FAIL b2b_new s=%0d got=%h exp=%h", s, mod_input, seq[s]); end
         checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL b2b_fs s=%0d got=%b exp=1", s, frame_start); end
      end
      checks++; if (underrun_sticky !== 1'b0) begin failures++; $display("FAIL b2b_underrun got=%b exp=0", underrun_sticky); end
   endtask

   task automatic test_underrun();
      do_reset();
      start(24'h123456);
      in_data = 24'h654321;
      step(8);
      checks++; if (mod_input !== 24'h654321) begin failures++; $display("FAIL ur_first got=%h exp=654321", mod_input); end
      checks++; if (underrun_sticky !== 1'b0) begin failures++; $display("FAIL ur_early got=%b exp=0", underrun_sticky); end
      in_valid = 1'b0; in_data = 24'h0F0F0F;
      step(8);
      checks++; if (mod_input !== 24'h654321) begin failures++; $display("FAIL ur_repeat got=%h exp=654321", mod_input); end
      checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL ur_fs got=%b exp=1", frame_start); end
      checks++; if (underrun_sticky !== 1'b1) begin failures++; $display("FAIL ur_set got=%b exp=1", underrun_sticky); end
      clear_flags = 1'b1;
      step(1);
      clear_flags = 1'b0;
      checks++; if (underrun_sticky !== 1'b0) begin failures++; $display("FAIL ur_clear got=%b exp=0", underrun_sticky); end
   endtask

   task automatic test_shutdown();
      do_reset();
      start(24'h0ABCDE);
      step(3);
      enable = 1'b0;
      step(4);
      checks++; if (mod_input !== 24'h0ABCDE) begin failures++; $display("FAIL sd_hold got=%h exp=0abcde", mod_input); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL sd_ready got=%b exp=0", in_ready); end
      step(1);
      checks++; if (mod_input !== '0) begin failures++; $display("FAIL sd_mute_in got=%h exp=0", mod_input); end
      checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL sd_fs got=%b exp=0", frame_start); end
      for (int k = 9; k <= 16; k++) begin
         step(1);
         checks++; if (bit_valid !== 1'b1 || mod_input !== '0) begin failures++; $display("FAIL sd_mute k=%0d got bv=%b in=%h exp bv=1 in=0", k, bit_valid, mod_input); end
      end
      step(1);
      checks++; if (bit_valid !== 1'b0) begin failures++; $display("FAIL sd_idle_bv got=%b exp=0", bit_valid); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL sd_idle_ready got=%b exp=0", in_ready); end
   endtask

   task automatic test_overload();
      do_reset();
      start(24'h000001);
      mod_bit = 1'b1;
      step(1);
      checks++; if (bit_out !== 1'b1) begin failures++; $display("FAIL ov_bit_out1 got=%b exp=1", bit_out); end
      step(3);
      checks++; if (overload !== 1'b0) begin failures++; $display("FAIL ov_k4 got=%b exp=0", overload); end
      step(1);
      checks++; if (overload !== 1'b1) begin failures++; $display("FAIL ov_k5 got=%b exp=1", overload); end
      checks++; if (overload_sticky !== 1'b0) begin failures++; $display("FAIL ov_sticky_k5 got=%b exp=0", overload_sticky); end
      step(1);
      checks++; if (overload !== 1'b1 || overload_sticky !== 1'b1) begin failures++; $display("FAIL ov_k6 got ov=%b st=%b exp ov=1 st=1", overload, overload_sticky); end
      mod_bit = 1'b0; clear_flags = 1'b1;
      step(1);
      clear_flags = 1'b0;
      checks++; if (overload !== 1'b1) begin failures++; $display("FAIL ov_k7 got=%b exp=1", overload); end
      checks++; if (overload_sticky !== 1'b1) begin failures++; $display("FAIL ov_set_wins got=%b exp=1", overload_sticky); end
      checks++; if (bit_out !== 1'b0) begin failures++; $display("FAIL ov_bit_out0 got=%b exp=0", bit_out); end
      step(1);
      checks++; if (overload !== 1'b0 || overload_sticky !== 1'b1) begin failures++; $display("FAIL ov_k8 got ov=%b st=%b exp ov=0 st=1", overload, overload_sticky); end
      clear_flags = 1'b1;
      step(1);
      clear_flags = 1'b0;
      checks++; if (overload_sticky !== 1'b0) begin failures++; $display("FAIL ov_clear got=%b exp=0", overload_sticky); end
   endtask

   task automatic test_async_reset();
      do_reset();
      mod_bit = 1'b1;
      start(24'h5A5A5A);
      step(3);
      checks++; if (bit_out !== 1'b1) begin failures++; $display("FAIL ar_pre_bit got=%b exp=1", bit_out); end
      #2 mod_reset_n = 1'b0;
      #1;
      checks++; if (mod_input !== '0) begin failures++; $display("FAIL ar_mod_input got=%h exp=0", mod_input); end
      checks++; if ({bit_out, bit_valid, frame_start, in_ready} !== 4'b0000) begin failures++; $display("FAIL ar_outs got=%b exp=0000", {bit_out, bit_valid, frame_start, in_ready}); end
      step(1);
      mod_reset_n = 1'b1; enable = 1'b0;
      step(2);
      checks++; if (in_ready !== 1'b0 || mod_input !== '0) begin failures++; $display("FAIL ar_idle got rdy=%b in=%h exp rdy=0 in=0", in_ready, mod_input); end
      checks++; if (bit_valid !== 1'b0) begin failures++; $display("FAIL ar_no_mute got=%b exp=0", bit_valid); end
      enable = 1'b1;
      step(1);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ar_fill_ready got=%b exp=1", in_ready); end
   endtask

   initial begin
      test_reset();
      test_startup();
      test_back_to_back();
      test_underrun();
      test_shutdown();
      test_overload();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
